// File: rtl/pc_gen_if.sv
// ---------------------------------------------------------------------------
// pc_gen_if
// Fetch request handshake between the PC generator and the instruction-fetch
// stage.
//   fetch_valid : fetch_pc is a valid fetch request        (PC gen -> IF)
//   fetch_pc    : current fetch PC                          (PC gen -> IF)
//   fetch_ready : IF accepts fetch_pc this cycle            (IF -> PC gen)
//   fetch_is_c  : accepted instruction is 16-bit            (IF -> PC gen)
// Modports: master = PC generator side, slave = IF side.
// ---------------------------------------------------------------------------
interface pc_gen_if #(
    parameter int XLEN = 32
);
    logic            fetch_valid;
    logic [XLEN-1:0] fetch_pc;
    logic            fetch_ready;
    logic            fetch_is_c;

    modport master (
        output fetch_valid,
        output fetch_pc,
        input  fetch_ready,
        input  fetch_is_c
    );

    modport slave (
        input  fetch_valid,
        input  fetch_pc,
        output fetch_ready,
        output fetch_is_c
    );
endinterface

// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen
// Fetch PC generator for the RISC-V front end. Holds the fetch PC, advances it
// by 2 or 4 on each accepted fetch, and applies prioritised redirects
// (trap > jump > predicted return). A circular return-address stack supplies
// the predicted-return target.
// Ports:
//   clk, rst_sync         : clock and synchronous active-high reset
//   fetch (master)        : fetch_valid/fetch_pc out, fetch_ready/fetch_is_c in
//   trap_valid, trap_vec  : trap redirect
//   jump, jump_addr       : execute-stage redirect
//   call_push, call_ret_addr : push a return address onto the RAS
//   ret_pop               : predicted return, redirect to RAS top
//   ras_count             : number of valid RAS entries (0..RAS_DEPTH)
//   ras_overflow          : sticky, a push dropped the oldest entry
//   misalign_err          : one-cycle pulse, last redirect target was misaligned
// All outputs are registered.
// ---------------------------------------------------------------------------
module pc_gen #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              RAS_DEPTH = 4,
    parameter bit              C_EXT     = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst_sync,
    pc_gen_if.master                     fetch,
    input  logic                         trap_valid,
    input  logic [XLEN-1:0]              trap_vec,
    input  logic                         jump,
    input  logic [XLEN-1:0]              jump_addr,
    input  logic                         call_push,
    input  logic [XLEN-1:0]              call_ret_addr,
    input  logic                         ret_pop,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         misalign_err
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // Low address bits that must be zero for an aligned target.
    localparam logic [XLEN-1:0] ALIGN_MASK = C_EXT ? XLEN'(1) : XLEN'(3);

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_TRAP,
        SEL_JUMP,
        SEL_RAS
    } redirect_e;

    logic [XLEN-1:0]  pc_q, pc_d;
    logic             valid_q;
    logic [PTR_W-1:0] ptr_q, ptr_d, top_ptr;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             mis_q, mis_d;
    logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
    logic             ras_we;
    logic [PTR_W-1:0] ras_waddr;
    redirect_e        sel;
    logic [XLEN-1:0]  target;
    logic [XLEN-1:0]  step;

    // Power-of-two depth lets the pointer wrap naturally.
    assign top_ptr = ptr_q - PTR_W'(1);
    assign step    = (C_EXT && fetch.fetch_is_c) ? XLEN'(2) : XLEN'(4);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        sel       = SEL_NONE;
        target    = '0;
        pc_d      = pc_q;
        mis_d     = 1'b0;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        ras_we    = 1'b0;
        ras_waddr = ptr_q;

        if (trap_valid) begin
            sel    = SEL_TRAP;
            target = trap_vec;
        end else if (jump) begin
            sel    = SEL_JUMP;
            target = jump_addr;
        end else if (ret_pop && cnt_q != '0) begin
            sel    = SEL_RAS;
            target = ras_mem[top_ptr];
        end

        if (sel != SEL_NONE) begin
            pc_d  = target & ~ALIGN_MASK;
            mis_d = |(target & ALIGN_MASK);
        end else if (valid_q && fetch.fetch_ready) begin
            pc_d = pc_q + step;
        end

        if (trap_valid) begin
            ptr_d = '0;
            cnt_d = '0;
        end else if (call_push && sel == SEL_RAS) begin
            // Pop and push together: the redirect already used the old top,
            // the new return address simply replaces it.
            ras_we    = 1'b1;
            ras_waddr = top_ptr;
        end else if (call_push) begin
            ras_we = 1'b1;
            ptr_d  = ptr_q + PTR_W'(1);
            if (cnt_q == CNT_W'(RAS_DEPTH)) begin
                ovf_d = 1'b1;   // oldest entry was just overwritten
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (sel == SEL_RAS) begin
            ptr_d = top_ptr;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            pc_q    <= RESET_VEC;
            valid_q <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= 1'b1;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            mis_q   <= mis_d;
        end
    end

    // NOTE: the RAS storage has no reset; entries are only read when cnt_q says they are valid.
    always_ff @(posedge clk) begin
        if (ras_we && !rst_sync) begin
            ras_mem[ras_waddr] <= call_ret_addr;
        end
    end

    assign fetch.fetch_valid = valid_q;
    assign fetch.fetch_pc    = pc_q;
    assign ras_count         = cnt_q;
    assign ras_overflow      = ovf_q;
    assign misalign_err      = mis_q;
endmodule

// File: tb/tb_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_pc_gen
// Drives two pc_gen instances (C_EXT=0 and C_EXT=1) with identical stimulus.
// A reference model (RAS kept as a plain queue) predicts the post-edge state
// of each instance; expectations are queued by the driver and popped by an
// independent monitor one delta after every rising edge.
// ---------------------------------------------------------------------------
module tb_pc_gen;
    localparam logic [31:0] RV = 32'h8000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        trap = 1'b0, jump = 1'b0, push = 1'b0, pop = 1'b0;
    logic        ready = 1'b0, is_c = 1'b0;
    logic [31:0] trap_vec = '0, jump_addr = '0, push_addr = '0;

    logic [2:0]  cnt0, cnt1;
    logic        ovf0, ovf1, mis0, mis1;

    pc_gen_if #(.XLEN(32)) if0 ();
    pc_gen_if #(.XLEN(32)) if1 ();
    assign if0.fetch_ready = ready;
    assign if0.fetch_is_c  = is_c;
    assign if1.fetch_ready = ready;
    assign if1.fetch_is_c  = is_c;

    pc_gen #(.XLEN(32), .RESET_VEC(RV), .RAS_DEPTH(4), .C_EXT(1'b0)) u_dut0 (
        .clk(clk), .rst_sync(rst), .fetch(if0),
        .trap_valid(trap), .trap_vec(trap_vec), .jump(jump), .jump_addr(jump_addr),
        .call_push(push), .call_ret_addr(push_addr), .ret_pop(pop),
        .ras_count(cnt0), .ras_overflow(ovf0), .misalign_err(mis0)
    );

    pc_gen #(.XLEN(32), .RESET_VEC(RV), .RAS_DEPTH(4), .C_EXT(1'b1)) u_dut1 (
        .clk(clk), .rst_sync(rst), .fetch(if1),
        .trap_valid(trap), .trap_vec(trap_vec), .jump(jump), .jump_addr(jump_addr),
        .call_push(push), .call_ret_addr(push_addr), .ret_pop(pop),
        .ras_count(cnt1), .ras_overflow(ovf1), .misalign_err(mis1)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
        logic [2:0]  cnt;
        logic        ovf;
        logic        mis;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_pc [2];
    bit          m_mis [2];
    bit          m_valid;
    bit          m_ovf;
    logic [31:0] m_ras [$];

    task automatic model_step();
        logic [31:0] tgt;
        bit          red;
        bit          popped;
        int unsigned align;
        if (rst) begin
            m_pc[0] = RV;
            m_pc[1] = RV;
            m_mis[0] = 1'b0;
            m_mis[1] = 1'b0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_ras.delete();
        end else begin
            red    = 1'b1;
            popped = 1'b0;
            if (trap) tgt = trap_vec;
            else if (jump) tgt = jump_addr;
            else if (pop && m_ras.size() > 0) begin
                tgt    = m_ras[m_ras.size()-1];
                popped = 1'b1;
            end else begin
                red = 1'b0;
                tgt = '0;
            end
            for (int i = 0; i < 2; i++) begin
                align = (i == 0) ? 4 : 2;
                if (red) begin
                    m_pc[i]  = tgt - (tgt % align);
                    m_mis[i] = (tgt % align) != 0;
                end else begin
                    m_mis[i] = 1'b0;
                    if (m_valid && ready)
                        m_pc[i] = m_pc[i] + ((i == 1 && is_c) ? 32'd2 : 32'd4);
                end
            end
            if (trap) begin
                m_ras.delete();
            end else if (push && popped) begin
                m_ras[m_ras.size()-1] = push_addr;
            end else if (push) begin
                if (m_ras.size() == 4) begin
                    void'(m_ras.pop_front());
                    m_ovf = 1'b1;
                end
                m_ras.push_back(push_addr);
            end else if (popped) begin
                void'(m_ras.pop_back());
            end
            m_valid = 1'b1;
        end
    endtask

    // Inputs are already set (at a falling edge); predict, queue, advance.
    task automatic cycle();
        exp_t e;
        model_step();
        e = '{pc: m_pc[0], valid: m_valid, cnt: 3'(m_ras.size()), ovf: m_ovf, mis: m_mis[0]};
        q0.push_back(e);
        e = '{pc: m_pc[1], valid: m_valid, cnt: 3'(m_ras.size()), ovf: m_ovf, mis: m_mis[1]};
        q1.push_back(e);
        @(negedge clk);
        rst  = 1'b0;
        trap = 1'b0;
        jump = 1'b0;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic do_jump(input logic [31:0] a);
        jump = 1'b1; jump_addr = a; cycle();
    endtask

    task automatic do_push(input logic [31:0] a);
        push = 1'b1; push_addr = a; cycle();
    endtask

    // ---------------- monitor ----------------
    // Every register updates each cycle, so each edge is a response to check.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check("dut0.fetch_pc",    64'(if0.fetch_pc),    64'(e.pc));
            check("dut0.fetch_valid", 64'(if0.fetch_valid), 64'(e.valid));
            check("dut0.ras_count",   64'(cnt0),            64'(e.cnt));
            check("dut0.ras_overflow",64'(ovf0),            64'(e.ovf));
            check("dut0.misalign_err",64'(mis0),            64'(e.mis));
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check("dut1.fetch_pc",    64'(if1.fetch_pc),    64'(e.pc));
            check("dut1.fetch_valid", 64'(if1.fetch_valid), 64'(e.valid));
            check("dut1.ras_count",   64'(cnt1),            64'(e.cnt));
            check("dut1.ras_overflow",64'(ovf1),            64'(e.ovf));
            check("dut1.misalign_err",64'(mis1),            64'(e.mis));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        @(negedge clk);

        // Reset for 3 cycles with ready high, then sequential fetch.
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin rst = 1'b1; cycle(); end
        for (int i = 0; i < 4; i++) cycle();

        // Hold while not ready, then jump while still not ready.
        ready = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        do_jump(32'h100);
        ready = 1'b1;
        cycle();

        // Pop on an empty RAS: sequential advance.
        pop = 1'b1; cycle();

        // Trap beats jump and return; RAS is flushed.
        do_push(32'hA0);
        do_push(32'hB0);
        trap = 1'b1; trap_vec = 32'h200; jump = 1'b1; jump_addr = 32'h300; pop = 1'b1;
        cycle();

        // Overflow: five pushes, then five pops.
        do_push(32'h10); do_push(32'h20); do_push(32'h30); do_push(32'h40); do_push(32'h50);
        for (int i = 0; i < 5; i++) begin pop = 1'b1; cycle(); end

        // Compressed steps and misaligned redirects.
        do_jump(32'h0);
        is_c = 1'b1; cycle();
        is_c = 1'b0; cycle();
        do_jump(32'h101);
        cycle();
        do_jump(32'h102);
        cycle();
        do_push(32'h0000_0123);
        pop = 1'b1; cycle();

        // Push and pop together, jump with push and pop.
        do_push(32'h400);
        do_push(32'h500);
        pop = 1'b1; push = 1'b1; push_addr = 32'h600; cycle();
        jump = 1'b1; jump_addr = 32'h700; pop = 1'b1; push = 1'b1; push_addr = 32'h800; cycle();
        pop = 1'b1; cycle();
        pop = 1'b1; cycle();

        // PC wrap, then reset during a push.
        do_jump(32'hFFFF_FFFC);
        cycle();
        cycle();
        do_push(32'h900);
        rst = 1'b1; push = 1'b1; push_addr = 32'hA00; cycle();
        cycle();

        // Randomised traffic.
        for (int n = 0; n < 800; n++) begin
            rst       = ($urandom_range(0, 199) == 0);
            trap      = ($urandom_range(0, 29) == 0);
            jump      = ($urandom_range(0, 9) == 0);
            push      = ($urandom_range(0, 4) == 0);
            pop       = ($urandom_range(0, 4) == 0);
            ready     = ($urandom_range(0, 3) != 0);
            is_c      = 1'($urandom_range(0, 1));
            trap_vec  = $urandom();
            jump_addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom();
            push_addr = $urandom();
            cycle();
        end

        @(negedge clk);
        check("scoreboard0_drained", 64'(q0.size()), 64'd0);
        check("scoreboard1_drained", 64'(q1.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
